// File: rtl/gps_transmitter.sv
// rtl/gps_transmitter.sv - GPZDA sentence generator, one byte per valid/ready handshake.
// The time port is named time_str because "time" is a reserved SystemVerilog type keyword.
module gps_transmitter #(
  parameter int               B         = 8,
  parameter logic [6*B-1:0]   Prefix    = "$GPZDA",
  parameter logic [B-1:0]     Separator = ",",
  parameter logic             NoCheck   = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [6*B-1:0]   time_str,
  input  logic [2*B-1:0]   day,
  input  logic [2*B-1:0]   month,
  input  logic [2*B-1:0]   year,
  output logic [B-1:0]     data,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {S_IDLE, S_PREFIX, S_BODY, S_CHECK, S_TAIL} state_t;

  state_t            state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [7:0]        cksum_q, cksum_d;
  logic [6*B-1:0]    time_q, time_d;
  logic [2*B-1:0]    day_q, day_d, month_q, month_d, year_q, year_d;
  logic              done_q, done_d;

  logic              fire;
  logic [6*B-1:0]    prefix_sh;
  logic [16*B-1:0]   body_sh;

  function automatic logic [B-1:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (B'(8'h30) + B'(n)) : (B'(8'h37) + B'(n));
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cksum_q <= '0;
      time_q  <= '0;
      day_q   <= '0;
      month_q <= '0;
      year_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cksum_q <= cksum_d;
      time_q  <= time_d;
      day_q   <= day_d;
      month_q <= month_d;
      year_q  <= year_d;
      done_q  <= done_d;
    end
  end

  // Output byte is a pure function of state, index and captured fields, so it
  // holds steady for as long as ready stays low.
  always_comb begin
    prefix_sh = Prefix << (idx_q * B);
    body_sh   = {Separator, time_q, Separator, day_q, Separator, month_q,
                 Separator, year_q} << (idx_q * B);
    data      = '0;
    case (state_q)
      S_PREFIX: data = prefix_sh[6*B-1 -: B];
      S_BODY:   data = body_sh[16*B-1 -: B];
      S_CHECK: begin
        case (idx_q)
          4'd0:    data = B'(8'h2A);
          4'd1:    data = hex_char(cksum_q[7:4]);
          default: data = hex_char(cksum_q[3:0]);
        endcase
      end
      S_TAIL:   data = (idx_q == 4'd0) ? B'(8'h0D) : B'(8'h0A);
      default:  data = '0;
    endcase
  end

  assign valid = (state_q != S_IDLE);
  assign busy  = (state_q != S_IDLE);
  assign done  = done_q;
  assign fire  = valid && ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cksum_d = cksum_q;
    time_d  = time_q;
    day_d   = day_q;
    month_d = month_q;
    year_d  = year_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          time_d  = time_str;
          day_d   = day;
          month_d = month;
          year_d  = year;
          cksum_d = '0;
          idx_d   = '0;
          state_d = S_PREFIX;
        end
      end
      default: begin
        if (fire) begin
          // Leading '$' is excluded from the checksum.
          if ((state_q == S_PREFIX && idx_q != 4'd0) || state_q == S_BODY) begin
            cksum_d = cksum_q ^ data[7:0];
          end
          idx_d = idx_q + 4'd1;
          case (state_q)
            S_PREFIX: if (idx_q == 4'd5) begin
              idx_d   = '0;
              state_d = S_BODY;
            end
            S_BODY: if (idx_q == 4'd15) begin
              idx_d   = '0;
              state_d = NoCheck ? S_TAIL : S_CHECK;
            end
            S_CHECK: if (idx_q == 4'd2) begin
              idx_d   = '0;
              state_d = S_TAIL;
            end
            default: if (idx_q == 4'd1) begin
              idx_d   = '0;
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          endcase
        end
      end
    endcase
  end

endmodule
